cond_flags_unit: RTL
====================

# cond_flags_unit

Consumer side of the ALU status path: holds the architectural flag register written from the 4-bit status word (Over, Zero, Neg, Carry) and evaluates 4-bit condition codes against it for conditional execution and branch resolution. Provides a small flag save/restore stack for interrupt entry and exit, and returns each condition result through a one-deep registered valid/ready output stage. Sits between the ALU status generator and the control unit's branch/predication logic.

## Interface

Parameters:
- STACK_DEPTH, default 4: number of flag-stack entries (power of two, at least 2).

Ports:
- Clock  in  1  rising-edge clock; the only clock.
- Resetn  in  1  asynchronous, active-low reset.
- StatusIn  in  4  flag word from the ALU: [3]=Over(V), [2]=Zero(Z), [1]=Neg(N), [0]=Carry(C).
- StatusWe  in  1  load StatusIn into the flag register this cycle.
- CondIn  in  4  condition code to evaluate.
- CondValid  in  1  CondIn is valid.
- CondReady  out  1  unit accepts CondIn this cycle.
- Taken  out  1  condition result, meaningful while TakeValid=1.
- TakeValid  out  1  Taken holds a result.
- TakeReady  in  1  downstream consumes the result.
- Push  in  1  save the current flag register to the stack.
- Pop  in  1  restore the flag register from the stack.
- Flags  out  4  current flag register.
- StackErr  out  1  one-cycle pulse on an illegal stack operation.

## Operation

- Condition codes, evaluated on the effective flags:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V). E AL: 1. F NV: 0.
- Effective flags are StatusIn when StatusWe=1 (same-cycle forwarding); otherwise they are the flag register.
- Flag register next value, in priority order:
  - StatusWe=1: StatusIn.
  - Else a legal Pop: the top stack entry.
  - Else unchanged.
- Stack is LIFO with a count of 0..STACK_DEPTH.
  - Push saves the pre-update flag register, even when StatusWe=1 in the same cycle.
  - A Pop is still performed when StatusWe=1; the popped value is discarded.
- Illegal stack operations:
  - Push when full, Pop when empty, or Push and Pop asserted together.
  - Effect: no stack change, no flag load from the stack, StackErr=1 for one cycle.
  - A StatusWe in the same cycle still takes effect.
- Output stage is one register with a valid bit.
  - CondReady = !TakeValid | TakeReady.
  - When CondValid & CondReady: Taken is loaded with the evaluation result and TakeValid is set to 1.
  - When TakeValid & TakeReady and no new accept: TakeValid is cleared.
- Flags output is the registered flag register; it is not forwarded.

## Timing

- Reset (asynchronous, Resetn=0):
  - Flags=0000, Taken=0, TakeValid=0, StackErr=0, stack count=0.
  - CondReady=1 immediately, since it derives from TakeValid.
- Latency: a condition accepted at edge k appears on Taken/TakeValid after edge k; one cycle.
- Throughput: one condition per cycle while TakeReady=1.
- Backpressure:
  - While TakeValid=1 and TakeReady=0, Taken and TakeValid hold and CondReady=0.
  - The flags used for a stalled CondIn are those in effect in the cycle it is accepted, not the cycle it was first presented.
- Flag writes: a StatusWe at edge k is visible on Flags after edge k. Push/Pop results are also visible one cycle later.
- StackErr is registered: it is asserted in the cycle after the offending edge and deasserts after one cycle unless the error repeats.
- Reset mid-operation discards any pending result and all stack contents.
- CondReady is combinational from TakeValid and TakeReady; no combinational path exists from CondValid to CondReady.

## Test plan

- Reset then evaluate all 16 codes with flags loaded to 0100 (Z=1) -> Taken = 1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,0 for codes 0..F, one result per cycle with TakeReady=1.
- Forwarding: Flags=0000; in the same cycle StatusWe=1 with StatusIn=1010 (V=1, N=1) and CondIn=A (GE) -> Taken=1 next cycle; Flags=1010 next cycle.
- Backpressure: TakeReady=0 with one result held -> CondReady=0 and Taken stable for 3 cycles. Then change flags to 0001 and release TakeReady; the next accepted CondIn=2 (CS) -> Taken=1.
- Stack:
  - Load 0001, Push, load 1000, Push, load 0100 in the same cycle as Pop -> Flags=0100 and the stack count is 1.
  - Then Pop -> Flags=0001.
- Stack errors with STACK_DEPTH=4:
  - Five Pushes -> StackErr pulses once, on the 5th Push.
  - Pop when empty -> StackErr pulses and Flags are unchanged.
  - Push and Pop asserted together -> StackErr pulses.
- Asynchronous reset asserted mid-cycle while TakeValid=1 and the stack count is 3 -> TakeValid=0 and Flags=0000 immediately. A subsequent Pop -> StackErr.

Source files
------------

// File: rtl/cond_flags_unit_if.sv
// cond_flags_unit_if
// Groups the flag-unit signals: ALU status load, condition request
// (valid/ready), registered condition result (valid/ready), flag stack
// push/pop, and the flag/error status outputs.
//   master : the side that drives the unit (ALU / control logic / bench)
//   slave  : the cond_flags_unit itself
interface cond_flags_unit_if;
    logic [3:0] StatusIn;   // [3]=V [2]=Z [1]=N [0]=C
    logic       StatusWe;
    logic [3:0] CondIn;
    logic       CondValid;
    logic       CondReady;
    logic       Taken;
    logic       TakeValid;
    logic       TakeReady;
    logic       Push;
    logic       Pop;
    logic [3:0] Flags;
    logic       StackErr;

    modport master (
        output StatusIn, StatusWe, CondIn, CondValid, TakeReady, Push, Pop,
        input  CondReady, Taken, TakeValid, Flags, StackErr
    );

    modport slave (
        input  StatusIn, StatusWe, CondIn, CondValid, TakeReady, Push, Pop,
        output CondReady, Taken, TakeValid, Flags, StackErr
    );
endinterface

// File: rtl/cond_flags_unit.sv
// cond_flags_unit
// Architectural flag register (V,Z,N,C) loaded from the ALU status word,
// condition-code evaluation with same-cycle forwarding of StatusIn, a LIFO
// flag save/restore stack, and a one-deep registered result stage.
// Ports:
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : cond_flags_unit_if.slave (status load, condition handshake,
//            result handshake, Push/Pop, Flags, StackErr)
module cond_flags_unit #(
    parameter int STACK_DEPTH = 4
) (
    input logic               Clock,
    input logic               Resetn,
    cond_flags_unit_if.slave  bus
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(STACK_DEPTH);

    logic [3:0]  flags_q, flags_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [3:0]  stk_q [STACK_DEPTH];
    logic        taken_q, taken_d;
    logic        tv_q, tv_d;
    logic        err_q, err_d;

    logic [3:0]  eff_flags;
    logic [AW:0] cnt_m1;
    logic        push_ok, pop_ok, accept, cond_ready;

    function automatic logic eval_cc(input logic [3:0] cc, input logic [3:0] f);
        logic v, z, n, c;
        v = f[3]; z = f[2]; n = f[1]; c = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c & !z;
            4'h9: return !c | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Conditions see a same-cycle ALU write; Flags output does not.
    assign eff_flags = bus.StatusWe ? bus.StatusIn : flags_q;

    // Simultaneous Push+Pop is illegal, so each op is legal only alone.
    assign push_ok = bus.Push & !bus.Pop & (cnt_q != FULL);
    assign pop_ok  = bus.Pop & !bus.Push & (cnt_q != '0);
    assign cnt_m1  = cnt_q - 1'b1;

    // Ready depends only on the output register, never on CondValid.
    assign cond_ready = !tv_q | bus.TakeReady;
    assign accept     = bus.CondValid & cond_ready;

    always_comb begin
        flags_d = flags_q;
        cnt_d   = cnt_q;
        err_d   = (bus.Push | bus.Pop) & !push_ok & !pop_ok;
        taken_d = taken_q;
        tv_d    = tv_q;

        if (push_ok)     cnt_d = cnt_q + 1'b1;
        else if (pop_ok) cnt_d = cnt_m1;

        // An ALU write wins over a restore; the popped entry is dropped.
        if (bus.StatusWe)  flags_d = bus.StatusIn;
        else if (pop_ok)   flags_d = stk_q[cnt_m1[AW-1:0]];

        if (accept) begin
            taken_d = eval_cc(bus.CondIn, eff_flags);
            tv_d    = 1'b1;
        end else if (bus.TakeReady) begin
            tv_d    = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            flags_q <= '0;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            tv_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            tv_q    <= tv_d;
            err_q   <= err_d;
            // Push saves the flags as they were before this cycle's update.
            if (push_ok) stk_q[cnt_q[AW-1:0]] <= flags_q;
        end
    end

    assign bus.CondReady = cond_ready;
    assign bus.Taken     = taken_q;
    assign bus.TakeValid = tv_q;
    assign bus.Flags     = flags_q;
    assign bus.StackErr  = err_q;
endmodule
